serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle, parametrised subtractor: computes diff = a - b - b_in over WIDTH bits.
//  Processes DIGIT bits per clock, LSB digit first, rippling the borrow between cycles.
//  Successor to the 1-bit full-subtractor cell, which it reuses as its datapath slice.
//  Sits between operand registers and any consumer that tolerates multi-cycle latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT, >= 2
//  DIGIT  1  bits processed per cycle; latency N = WIDTH/DIGIT cycles
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only while busy=0
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  b_in        in   1      borrow-in, captured on accepted start
//  busy        out  1      high while a subtraction is in progress
//  done        out  1      one-cycle pulse: diff/borrow/overflow valid
//  diff        out  WIDTH  result, held stable until the next accepted start completes
//  borrow      out  1      final borrow-out (1 => a < b + b_in, unsigned)
//  overflow    out  1      signed overflow of a - b - b_in (two's complement)
// BEHAVIOUR
//  Interface: one clock (clk). Reset rst is asynchronous and active-high.
//  - Reset state: FSM=IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, counter=0.
//  - States: IDLE, RUN. Transitions are taken on the clk rising edge.
//    - IDLE: start=1 -> latch a, b, b_in. Borrow register <= b_in, counter <= 0,
//      busy <= 1, go to RUN.
//    - RUN: each edge feeds the low DIGIT bits of the a/b shift registers and the
//      borrow register through DIGIT chained cells. Result digit enters diff shift
//      register from the MSB side. Operands shift right by DIGIT. Counter increments.
//    - RUN, counter = N-1: final digit is processed. On the same edge: busy <= 0,
//      done <= 1, borrow <= cell borrow-out, overflow <= (a[MSB]!=b[MSB]) &&
//      (diff[MSB]!=a[MSB]) from the latched operands. Go to IDLE.
//  - Latency: start sampled at edge k -> done=1 in the cycle after edge k+N.
//  - done is high for exactly one cycle.
//  - Back-to-back: start=1 in the done cycle is accepted. busy rises again at the next edge.
//  - start while busy=1 is ignored. No queuing, no effect on the in-flight operation.
//  - diff, borrow and overflow update only at completion (internal shift register separate
//    from the output register). Outputs never expose partial results.
//  - Inputs a, b, b_in may change freely after the accepting edge.
//  - Arithmetic is modulo 2^WIDTH. borrow and overflow are independent flags.
//  - Reset mid-operation: the async clear aborts the operation immediately. Every output
//    takes its reset value, and no done pulse is produced for the aborted operation.
//  - Counter width: $clog2(N) bits, minimum 1. No wrap beyond N-1.
// STRUCTURE
//  - Shared package sub_pkg: FSM state typedef (IDLE, RUN) and a helper function
//    sub_ref(a, b, b_in) returning {borrow, diff}. The bench uses it as the golden model.
//  - One sub-module: full_subtractor_cell (1-bit: diff = a^b^bin,
//    bout = (~a&b) | (~(a^b)&bin)). Instantiated DIGIT times in a ripple chain via generate.
//  - Top level holds the FSM, counter, operand/result shift registers and output registers.
// TESTING
//  1. W=8,D=1: a=0x05, b=0x03, b_in=0 -> after 8 cycles done=1, diff=0x02, borrow=0, overflow=0.
//  2. W=8,D=1: a=0x00, b=0x01, b_in=0 -> diff=0xFF, borrow=1, overflow=0.
//     Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1.
//  3. W=8,D=1: a=0x00, b=0xFF, b_in=1 -> diff=0x00, borrow=1.
//     Then start held high in the done cycle -> a second operation is accepted, with no idle gap.
//  4. Pulse start again at cycle 3 of an operation with different operands -> ignored.
//     Result matches the first operands, and exactly one done pulse occurs.
//  5. Assert rst at cycle 4 of a run -> busy, done, diff and borrow go to 0 immediately.
//     No done follows. A new start after reset completes correctly.
//  6. W=8,D=4 (done at latency 2) and W=3,D=1 exhaustive (all 128 a/b/b_in combos)
//     -> every result equals sub_ref.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
//   state_e : FSM state encoding (IDLE, RUN)
//   sub_ref : arithmetic reference returning {borrow, diff} for an operand
//             width of up to REF_W bits. Bit REF_W holds the borrow, and the
//             low bits hold the difference masked to 'width' bits.
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int REF_W = 64;

  function automatic logic [REF_W:0] sub_ref(input logic [REF_W-1:0] a,
                                             input logic [REF_W-1:0] b,
                                             input logic             b_in,
                                             input int               width);
    logic [REF_W-1:0] mask;
    logic [REF_W:0]   full;
    mask = (width >= REF_W) ? '1 : ((REF_W'(1) << width) - REF_W'(1));
    // One extra bit of headroom: a negative result sets the top bit, which is the borrow.
    full = {1'b0, a & mask} - {1'b0, b & mask} - (REF_W+1)'(b_in);
    sub_ref = {full[REF_W], full[REF_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor slice: diff_o = a_i - b_i - bin_i.
//   a_i, b_i : operand bits
//   bin_i    : borrow in
//   diff_o   : difference bit
//   bout_o   : borrow out
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in (mod 2^WIDTH), DIGIT bits per
// clock, least significant digit first, borrow rippled between cycles.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   start          : request, sampled only while busy is low
//   a, b, b_in     : operands, captured on the accepting edge
//   busy           : operation in progress
//   done           : one-cycle pulse, diff/borrow/overflow valid from here on
//   diff           : result, held until the next operation completes
//   borrow         : final unsigned borrow-out
//   overflow       : two's complement overflow of a - b - b_in
//   state_o        : current FSM state
//
// Handshake: start is a request sampled on a rising clock edge only while
// busy is low; the edge that sees start=1 with busy=0 captures the operands
// and raises busy. Starts seen while busy is high are dropped. Completion is
// signalled by a single-cycle done pulse, and start may be asserted in that
// same cycle to begin the next operation without a gap.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output state_e           state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             bor_q, bor_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] r_nxt;

  assign chain[0] = bor_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a_i    (a_sh_q[i]),
      .b_i    (b_sh_q[i]),
      .bin_i  (chain[i]),
      .diff_o (dig[i]),
      .bout_o (chain[i+1])
    );
  end

  // Result digits enter from the MSB side, so after N steps the first digit
  // computed sits in the least significant position.
  if (N == 1) begin : g_one
    assign r_nxt = dig;
  end else begin : g_many
    assign r_nxt = {dig, r_sh_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    bor_d    = bor_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = b_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        r_sh_d = r_nxt;
        bor_d  = chain[DIGIT];
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          diff_d   = r_nxt;
          borrow_d = chain[DIGIT];
          ovf_d    = (a_msb_q != b_msb_q) && (r_nxt[WIDTH-1] != a_msb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      bor_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      bor_q    <= bor_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // W=8, D=1
  logic       start8, bin8, busy8, done8, bor8, ovf8;
  logic [7:0] a8, b8, diff8;
  state_e     st8;
  // W=8, D=4
  logic       start84, bin84, busy84, done84, bor84, ovf84;
  logic [7:0] a84, b84, diff84;
  state_e     st84;
  // W=3, D=1
  logic       start3, bin3, busy3, done3, bor3, ovf3;
  logic [2:0] a3, b3, diff3;
  state_e     st3;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(bor8), .overflow(ovf8),
    .state_o(st8));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(start84), .a(a84), .b(b84), .b_in(bin84),
    .busy(busy84), .done(done84), .diff(diff84), .borrow(bor84), .overflow(ovf84),
    .state_o(st84));

  serial_subtractor #(.WIDTH(3), .DIGIT(1)) u_w3d1 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .b_in(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow(bor3), .overflow(ovf3),
    .state_o(st3));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference for 8-bit operands: {overflow, borrow, diff} from integer arithmetic.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int ud, sd;
    logic [7:0] d;
    ud = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = 8'(ud);
    model8 = {(sd < -128 || sd > 127), (ud < 0), d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
    check("busy8_after_accept", 64'(busy8), 64'(1));
    lat = 0;
    while (!done8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    d = diff8; bo = bor8; ov = ovf8;
    @(negedge clk);
    check("done8_one_cycle", 64'(done8), 64'(0));
  endtask

  task automatic run84(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    a84 = a; b84 = b; bin84 = bin; start84 = 1'b1;
    @(negedge clk);
    start84 = 1'b0;
    a84 = 8'($urandom); b84 = 8'($urandom);
    lat = 0;
    while (!done84 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    d = diff84; bo = bor84; ov = ovf84;
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                      output logic [2:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    a3 = a; b3 = b; bin3 = bin; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    d = diff3; bo = bor3; ov = ovf3;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t       tbl [9];
    logic [7:0] d;
    logic       bo, ov;
    logic [2:0] d3;
    logic [9:0] m;
    logic [64:0] r;
    int         lat, ndone, sd3;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[7] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{8'hC3, 8'h5A, 1'b1, 8'h68, 1'b0, 1'b1};

    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start84 = 0; a84 = 0; b84 = 0; bin84 = 0;
    start3 = 0; a3 = 0; b3 = 0; bin3 = 0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_done", 64'(done8), 64'(0));
    check("rst_diff", 64'(diff8), 64'(0));
    check("rst_borrow", 64'(bor8), 64'(0));
    check("rst_overflow", 64'(ovf8), 64'(0));
    check("rst_state", 64'(st8), 64'(IDLE));
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 9; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, ov, lat);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(8));
      check($sformatf("tbl%0d_diff", i), 64'(d), 64'(tbl[i].d));
      check($sformatf("tbl%0d_borrow", i), 64'(bo), 64'(tbl[i].bo));
      check($sformatf("tbl%0d_overflow", i), 64'(ov), 64'(tbl[i].ov));
    end

    // back-to-back: start held high in the done cycle
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 64'(lat), 64'(8));
    check("b2b_first_diff", 64'(diff8), 64'(8'h00));
    check("b2b_first_borrow", 64'(bor8), 64'(1));
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_no_gap_busy", 64'(busy8), 64'(1));
    check("b2b_done_dropped", 64'(done8), 64'(0));
    check("b2b_diff_held", 64'(diff8), 64'(8'h00));
    lat = 0;
    while (!done8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 64'(lat), 64'(8));
    check("b2b_second_diff", 64'(diff8), 64'(8'h02));
    check("b2b_second_borrow", 64'(bor8), 64'(0));

    // start pulsed mid-operation is ignored
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
      end
      if (c == 4) start8 = 1'b0;
      @(negedge clk);
      if (done8) begin
        ndone++;
        d = diff8; bo = bor8; ov = ovf8;
      end
    end
    check("ignore_done_count", 64'(ndone), 64'(1));
    check("ignore_diff", 64'(d), 64'(8'h02));
    check("ignore_borrow", 64'(bo), 64'(0));
    check("ignore_overflow", 64'(ov), 64'(0));

    // reset mid-operation: leave nonzero outputs first
    run8(8'h7F, 8'hFF, 1'b0, d, bo, ov, lat);
    check("pre_rst_diff", 64'(d), 64'(8'h80));
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy8), 64'(0));
    check("midrst_done", 64'(done8), 64'(0));
    check("midrst_diff", 64'(diff8), 64'(0));
    check("midrst_borrow", 64'(bor8), 64'(0));
    check("midrst_overflow", 64'(ovf8), 64'(0));
    check("midrst_state", 64'(st8), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'(0));
    run8(8'h80, 8'h01, 1'b0, d, bo, ov, lat);
    check("postrst_latency", 64'(lat), 64'(8));
    check("postrst_diff", 64'(d), 64'(8'h7F));
    check("postrst_borrow", 64'(bo), 64'(0));
    check("postrst_overflow", 64'(ov), 64'(1));

    // random operands, W=8 D=1
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom_range(0, 1));
      m = model8(ra, rb, rbin);
      run8(ra, rb, rbin, d, bo, ov, lat);
      check("rnd8_latency", 64'(lat), 64'(8));
      check($sformatf("rnd8_diff a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(d), 64'(m[7:0]));
      check($sformatf("rnd8_borrow a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(bo), 64'(m[8]));
      check($sformatf("rnd8_overflow a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(ov), 64'(m[9]));
    end

    // random operands, W=8 D=4
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom_range(0, 1));
      m = model8(ra, rb, rbin);
      run84(ra, rb, rbin, d, bo, ov, lat);
      check("d4_latency", 64'(lat), 64'(2));
      check($sformatf("d4_diff a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(d), 64'(m[7:0]));
      check($sformatf("d4_borrow a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(bo), 64'(m[8]));
      check($sformatf("d4_overflow a=%0h b=%0h bin=%0d", ra, rb, rbin), 64'(ov), 64'(m[9]));
    end

    // exhaustive W=3 D=1
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r = sub_ref(64'(ia), 64'(ib), 1'(ic), 3);
          sd3 = ((ia > 3) ? ia - 8 : ia) - ((ib > 3) ? ib - 8 : ib) - ic;
          run3(3'(ia), 3'(ib), 1'(ic), d3, bo, ov, lat);
          check("w3_latency", 64'(lat), 64'(3));
          check($sformatf("w3_diff a=%0d b=%0d bin=%0d", ia, ib, ic), 64'(d3), 64'(r[2:0]));
          check($sformatf("w3_borrow a=%0d b=%0d bin=%0d", ia, ib, ic), 64'(bo), 64'(r[64]));
          check($sformatf("w3_overflow a=%0d b=%0d bin=%0d", ia, ib, ic), 64'(ov),
                64'(sd3 < -4 || sd3 > 3));
        end
      end
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
